// File: rtl/if_filter_pkg.sv
// -----------------------------------------------------------------------------
// if_filter_pkg
// Shared widths, output rails, tap coefficients, gain codes and small
// arithmetic helpers for the IF band-pass filter stage.
// -----------------------------------------------------------------------------
package if_filter_pkg;

   localparam int IN_W  = 4;   // signed IF sample width
   localparam int OUT_W = 6;   // signed saturated output width
   localparam int ACC_W = 8;   // accumulator width, holds -60..60

   localparam int NTAPS = 7;

   localparam int OUT_MAX = 31;
   localparam int OUT_MIN = -32;

   // h = (1 - z^-2)^3: zeros at DC and Nyquist, gain 8 at fs/4.
   // Odd taps are zero and are never read by the accumulator.
   localparam int H0 = 1;
   localparam int H1 = 0;
   localparam int H2 = -3;
   localparam int H3 = 0;
   localparam int H4 = 3;
   localparam int H5 = 0;
   localparam int H6 = -1;

   // gain_spi codes
   localparam logic [1:0] G_HALF = 2'd0;
   localparam logic [1:0] G_X1   = 2'd1;
   localparam logic [1:0] G_X2   = 2'd2;
   localparam logic [1:0] G_X4   = 2'd3;

   // Sign-extend an input sample to accumulator width.
   function automatic logic signed [ACC_W-1:0] sx(input logic signed [IN_W-1:0] v);
      return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
   endfunction

   // 3*v as shift-and-add; no multiplier.
   function automatic logic signed [ACC_W-1:0] times3(input logic signed [IN_W-1:0] v);
      logic signed [ACC_W-1:0] s;
      s = sx(v);
      return (s <<< 1) + s;
   endfunction

endpackage

// File: rtl/if_gain_sat.sv
// -----------------------------------------------------------------------------
// if_gain_sat
// Combinational gain scaling (x0.5 floor, x1, x2, x4) followed by clamping
// to the signed output range [OUT_MIN, OUT_MAX].
// Ports:
//   acc      in  ACC_W signed  filter accumulator
//   gain     in  2             gain code (G_HALF/G_X1/G_X2/G_X4)
//   sat_out  out OUT_W signed  scaled and saturated value
// -----------------------------------------------------------------------------
module if_gain_sat
   import if_filter_pkg::*;
(
   input  logic signed [ACC_W-1:0] acc,
   input  logic        [1:0]       gain,
   output logic signed [OUT_W-1:0] sat_out
);

   // Two extra bits absorb the x4 shift of the largest accumulator value.
   localparam int SCL_W = ACC_W + 2;

   localparam logic signed [SCL_W-1:0] SAT_HI = SCL_W'(OUT_MAX);
   localparam logic signed [SCL_W-1:0] SAT_LO = SCL_W'(OUT_MIN);

   logic signed [SCL_W-1:0] acc_ext;
   logic signed [SCL_W-1:0] scaled;

   assign acc_ext = {{(SCL_W-ACC_W){acc[ACC_W-1]}}, acc};

   always_comb begin
      scaled = acc_ext;
      case (gain)
         G_HALF:  scaled = acc_ext >>> 1;   // arithmetic: rounds toward -inf
         G_X1:    scaled = acc_ext;
         G_X2:    scaled = acc_ext <<< 1;
         G_X4:    scaled = acc_ext <<< 2;
         default: scaled = acc_ext;
      endcase
   end

   always_comb begin
      sat_out = scaled[OUT_W-1:0];
      if (scaled > SAT_HI)
         sat_out = OUT_W'(OUT_MAX);
      else if (scaled < SAT_LO)
         sat_out = OUT_W'(OUT_MIN);
   end

endmodule

// File: rtl/if_filter.sv
// -----------------------------------------------------------------------------
// if_filter
// IF band-pass stage: 7-tap FIR (1 - z^-2)^3 centred at fs/4, programmable
// gain, saturation and a registered signed output.
// Ports:
//   clk          in   1      system clock, one sample per rising edge
//   rst_n        in   1      asynchronous active-low reset
//   if_out       in   IN_W   signed IF sample from the mixer
//   gain_spi     in   2      gain select, quasi-static
//   if_filt_out  out  OUT_W  signed filtered, gained, saturated sample
// -----------------------------------------------------------------------------
module if_filter
   import if_filter_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [IN_W-1:0]  if_out,
   input  logic        [1:0]       gain_spi,
   output logic signed [OUT_W-1:0] if_filt_out
);

   logic signed [IN_W-1:0]  x_reg [0:NTAPS-1];
   logic signed [ACC_W-1:0] acc_next;
   logic signed [OUT_W-1:0] sat_next;

   // Delay line: x[0] takes the new sample, older taps shift down.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NTAPS; i++)
            x_reg[i] <= '0;
      end else begin
         x_reg[0] <= if_out;
         for (int i = 1; i < NTAPS; i++)
            x_reg[i] <= x_reg[i-1];
      end
   end

   // Only the even taps contribute; |acc| <= 60 so ACC_W never wraps.
   assign acc_next = sx(x_reg[0]) - times3(x_reg[2]) + times3(x_reg[4]) - sx(x_reg[6]);

   if_gain_sat u_gain_sat (
      .acc     (acc_next),
      .gain    (gain_spi),
      .sat_out (sat_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         if_filt_out <= '0;
      else
         if_filt_out <= sat_next;
   end

endmodule

// File: tb/tb_if_filter.sv
// -----------------------------------------------------------------------------
// tb_if_filter
// Directed bench for if_filter: reset, impulse responses at several gains,
// fs/4 tone passband with saturation, DC/Nyquist rejection and async reset
// in the middle of a stream.
// -----------------------------------------------------------------------------
module tb_if_filter;

   logic             clk;
   logic             rst_n;
   logic signed [3:0] if_out;
   logic [1:0]       gain_spi;
   logic signed [5:0] if_filt_out;

   int total = 0;
   int bad   = 0;

   if_filter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_out      (if_out),
      .gain_spi    (gain_spi),
      .if_filt_out (if_filt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s got=%0d", tag, got);
      end
   endtask

   // Present one sample; returns on the following falling edge, after the
   // rising edge that captured it.
   task automatic push(input int v);
      if_out = 4'(v);
      @(negedge clk);
   endtask

   // Impulse of height 7 then zeros; checks 8 outputs after edges k+1..k+8.
   task automatic impulse(input logic [1:0] g, input int e0, input int e2,
                          input int e4, input int e6, input string tag);
      int exp_tab [8];
      exp_tab = '{e0, 0, e2, 0, e4, 0, e6, 0};
      gain_spi = g;
      push(7);
      for (int i = 0; i < 8; i++) begin
         push(0);
         check_val($sformatf("%s[%0d]", tag, i), int'(if_filt_out), exp_tab[i]);
      end
   endtask

   initial begin
      int tone [4];
      int exp4 [4];
      tone = '{4, 0, -4, 0};

      rst_n    = 1'b0;
      gain_spi = 2'd1;
      if_out   = '0;

      // Reset held with toggling input: output must stay 0.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if_out = (i % 2 == 0) ? 4'sd7 : -4'sd8;
         @(negedge clk);
         check_val($sformatf("rst_hold[%0d]", i), int'(if_filt_out), 0);
      end

      // Release with zero input: stays 0.
      rst_n  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(0);
         check_val($sformatf("rst_rel[%0d]", i), int'(if_filt_out), 0);
      end

      impulse(2'd1,  7, -21, 21,  -7, "imp_g1");
      impulse(2'd0,  3, -11, 10,  -4, "imp_g0");
      impulse(2'd3, 28, -32, 31, -28, "imp_g3");

      // fs/4 tone at gain 2 saturates at both rails.
      gain_spi = 2'd2;
      exp4 = '{31, 0, -32, 0};
      for (int i = 0; i < 12; i++) begin
         push(tone[i % 4]);
         if (i >= 8)
            check_val($sformatf("tone_g2[%0d]", i), int'(if_filt_out), exp4[(i-1) % 4]);
      end
      for (int i = 0; i < 8; i++) push(0);

      // DC rejection at gain 3.
      gain_spi = 2'd3;
      for (int i = 0; i < 11; i++) begin
         push(5);
         if (i >= 8)
            check_val($sformatf("dc_g3[%0d]", i), int'(if_filt_out), 0);
      end
      for (int i = 0; i < 8; i++) push(0);

      // Nyquist rejection at gain 3.
      for (int i = 0; i < 11; i++) begin
         push((i % 2 == 0) ? 5 : -5);
         if (i >= 8)
            check_val($sformatf("nyq_g3[%0d]", i), int'(if_filt_out), 0);
      end
      for (int i = 0; i < 8; i++) push(0);

      // fs/4 tone at gain 0: +-32 halved to +-16.
      gain_spi = 2'd0;
      exp4 = '{16, 0, -16, 0};
      for (int i = 0; i < 10; i++) begin
         push(tone[i % 4]);
         if (i >= 8)
            check_val($sformatf("tone_g0[%0d]", i), int'(if_filt_out), exp4[(i-1) % 4]);
      end

      // Async reset between edges: output clears with no clock edge.
      #2 rst_n = 1'b0;
      #1 check_val("arst_now", int'(if_filt_out), 0);
      @(negedge clk);
      check_val("arst_hold", int'(if_filt_out), 0);

      // Release; history must be all zeros, so only the new 4 shows up.
      gain_spi = 2'd1;
      rst_n    = 1'b1;
      push(4);
      check_val("post_rst[0]", int'(if_filt_out), 0);
      push(0);
      check_val("post_rst[1]", int'(if_filt_out), 4);
      push(0);
      check_val("post_rst[2]", int'(if_filt_out), 0);
      push(0);
      check_val("post_rst[3]", int'(if_filt_out), -12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
